// File: rtl/alu_acc.sv
// alu_acc: 4-bit accumulator executor with valid/ready command and result channels.
module alu_acc (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       res_zero,
    output logic       res_over,
    output logic       res_carry,
    output logic [3:0] acc,
    output logic [7:0] op_count
);

    localparam int unsigned W  = 4;
    localparam int unsigned OW = 3;
    localparam int unsigned CW = 8;

    localparam logic [OW-1:0] OP_ADD  = 3'b000;
    localparam logic [OW-1:0] OP_SUB  = 3'b001;
    localparam logic [OW-1:0] OP_LOAD = 3'b010;
    localparam logic [OW-1:0] OP_AND  = 3'b011;
    localparam logic [OW-1:0] OP_OR   = 3'b100;
    localparam logic [OW-1:0] OP_XOR  = 3'b101;
    localparam logic [OW-1:0] OP_SLT  = 3'b110;
    localparam logic [OW-1:0] OP_EQ   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [OW-1:0] op_q;
    logic [W-1:0]  b_q;
    logic          cmd_fire;

    logic [W:0]    sum_add;
    logic [W:0]    sum_sub;
    logic [W-1:0]  xb;
    logic          ovf_add;
    logic          ovf_sub;
    logic [W-1:0]  alu_res;
    logic          alu_zero;
    logic          alu_over;
    logic          alu_carry;

    // Handshake decode: clr in IDLE blocks acceptance.
    assign cmd_ready = (state == IDLE) && !clr;
    assign res_valid = (state == HOLD);
    assign cmd_fire  = cmd_valid && cmd_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire) state_nxt = EXEC;
            EXEC:    state_nxt = HOLD;
            HOLD:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared adder paths; SLT and EQ reuse the subtract result.
    always_comb begin
        xb      = ~b_q;
        sum_add = (W+1)'({1'b0, acc}) + (W+1)'({1'b0, b_q});
        sum_sub = (W+1)'({1'b0, acc}) + (W+1)'({1'b0, xb}) + (W+1)'(1);
        ovf_add = (acc[W-1] == b_q[W-1]) && (sum_add[W-1] != acc[W-1]);
        ovf_sub = (acc[W-1] == xb[W-1])  && (sum_sub[W-1] != acc[W-1]);
    end

    // Operation select: result plus flags.
    always_comb begin
        alu_res   = '0;
        alu_zero  = 1'b0;
        alu_over  = 1'b0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res   = sum_add[W-1:0];
                alu_carry = sum_add[W];
                alu_over  = ovf_add;
                alu_zero  = (sum_add[W-1:0] == '0);
            end
            OP_SUB: begin
                alu_res   = sum_sub[W-1:0];
                alu_carry = sum_sub[W];
                alu_over  = ovf_sub;
                alu_zero  = (sum_sub[W-1:0] == '0);
            end
            OP_LOAD: begin
                alu_res  = b_q;
                alu_zero = (b_q == '0);
            end
            OP_AND: begin
                alu_res  = acc & b_q;
                alu_zero = ((acc & b_q) == '0);
            end
            OP_OR: begin
                alu_res  = acc | b_q;
                alu_zero = ((acc | b_q) == '0);
            end
            OP_XOR: begin
                alu_res  = acc ^ b_q;
                alu_zero = ((acc ^ b_q) == '0);
            end
            OP_SLT: begin
                alu_res   = W'(ovf_sub ^ sum_sub[W-1]);
                alu_carry = sum_sub[W];
                alu_over  = ovf_sub;
                alu_zero  = (sum_sub[W-1:0] == '0);
            end
            default: begin
                alu_res   = W'(sum_sub[W-1:0] == '0);
                alu_carry = sum_sub[W];
                alu_over  = ovf_sub;
                alu_zero  = (sum_sub[W-1:0] == '0);
            end
        endcase
    end

    // Datapath registers: command latch, accumulator, result, flags, op counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            b_q       <= '0;
            acc       <= '0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_over  <= 1'b0;
            res_carry <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        acc <= '0;
                    end else if (cmd_valid) begin
                        op_q <= cmd_op;
                        b_q  <= cmd_data;
                    end
                end
                EXEC: begin
                    acc       <= alu_res;
                    res_data  <= alu_res;
                    res_zero  <= alu_zero;
                    res_over  <= alu_over;
                    res_carry <= alu_carry;
                end
                HOLD: begin
                    if (res_ready) op_count <= op_count + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc.sv
// Directed testbench for alu_acc.
module tb_alu_acc;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_zero;
    logic       res_over;
    logic       res_carry;
    logic [3:0] acc;
    logic [7:0] op_count;

    int tests;
    int failed;
    int exp_cnt;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, LOAD = 3'b010, AND_ = 3'b011;
    localparam logic [2:0] OR_ = 3'b100, XOR_ = 3'b101, SLT = 3'b110, EQ = 3'b111;

    alu_acc dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_over  (res_over),
        .res_carry (res_carry),
        .acc       (acc),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command at a negedge; wait (bounded) for acceptance and then res_valid.
    task automatic issue(input logic [2:0] op, input logic [3:0] d);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 8'(cmd_ready), 8'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) check("result_timeout", 8'(res_valid), 8'd1);
    endtask

    // Complete the result handshake.
    task automatic handshake();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
    endtask

    task automatic check_res(input string tag, input logic [3:0] d, input logic [2:0] czo);
        check({tag, "_data"}, 8'(res_data), 8'(d));
        check({tag, "_flags"}, 8'({res_carry, res_zero, res_over}), 8'(czo));
    endtask

    initial begin
        tests = 0; failed = 0; exp_cnt = 0;
        rst = 1'b1; clr = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; res_ready = 1'b0;
        #1;
        check("rst_acc",       8'(acc), 8'd0);
        check("rst_res_valid", 8'(res_valid), 8'd0);
        check("rst_cmd_ready", 8'(cmd_ready), 8'd1);
        check("rst_res",       8'({res_data, res_carry, res_zero, res_over}), 8'd0);
        check("rst_op_count",  op_count, 8'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Latency: accepted at edge N, res_valid after edge N+1.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = LOAD; cmd_data = 4'd7;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("exec_cmd_ready", 8'(cmd_ready), 8'd0);
        check("exec_res_valid", 8'(res_valid), 8'd0);
        @(posedge clk);
        #1 check("hold_res_valid", 8'(res_valid), 8'd1);
        // flags as {carry, zero, over}
        check_res("load7", 4'd7, 3'b000);
        handshake();

        issue(ADD, 4'd5);
        check_res("add5", 4'b1100, 3'b001);
        check("add5_acc", 8'(acc), 8'hc);
        handshake();
        check("cnt2", op_count, 8'(exp_cnt));

        issue(LOAD, 4'd3); handshake();
        issue(SUB, 4'd5);
        check_res("sub5", 4'b1110, 3'b000);
        handshake();
        issue(SUB, 4'd14);
        check_res("sub14", 4'b0000, 3'b110);
        handshake();

        // -8 - 1 overflows, so SLT still reports less via over ^ diff[3].
        issue(LOAD, 4'd8); handshake();
        issue(SLT, 4'd1);
        check_res("slt", 4'b0001, 3'b101);
        handshake();
        issue(LOAD, 4'd4); handshake();
        issue(EQ, 4'd4);
        check_res("eq4", 4'b0001, 3'b110);
        handshake();
        issue(EQ, 4'd5);
        check_res("eq5", 4'b0000, 3'b000);
        handshake();

        issue(LOAD, 4'b1100); handshake();
        issue(AND_, 4'b1010);
        check_res("and", 4'b1000, 3'b000); handshake();
        issue(OR_, 4'b0011);
        check_res("or", 4'b1011, 3'b000); handshake();
        issue(XOR_, 4'b1011);
        check_res("xor", 4'b0000, 3'b010); handshake();

        // Backpressure: result held, new command refused, counter frozen.
        issue(ADD, 4'd9);
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_op = LOAD; cmd_data = 4'd2;
            @(negedge clk);
            check("bp_valid", 8'(res_valid), 8'd1);
            check("bp_cmd_ready", 8'(cmd_ready), 8'd0);
            check_res("bp", 4'd9, 3'b000);
            check("bp_cnt", op_count, 8'(exp_cnt));
        end
        cmd_valid = 1'b0;
        handshake();
        check("bp_cnt_after", op_count, 8'(exp_cnt));
        check("bp_acc", 8'(acc), 8'd9);
        check("bp_res_hold", 8'(res_data), 8'd9);

        // clr with cmd_valid in IDLE: clear wins, nothing accepted.
        @(negedge clk);
        clr = 1'b1; cmd_valid = 1'b1; cmd_op = LOAD; cmd_data = 4'd5;
        #1 check("clr_cmd_ready", 8'(cmd_ready), 8'd0);
        @(negedge clk);
        clr = 1'b0; cmd_valid = 1'b0;
        check("clr_acc", 8'(acc), 8'd0);
        check("clr_res_kept", 8'(res_data), 8'd9);
        @(negedge clk); @(negedge clk);
        check("clr_no_accept", 8'(res_valid), 8'd0);
        check("clr_cnt", op_count, 8'(exp_cnt));

        // clr in HOLD is ignored.
        issue(LOAD, 4'd9);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_hold_acc", 8'(acc), 8'd9);
        check("clr_hold_valid", 8'(res_valid), 8'd1);
        handshake();
        check("clr_hold_acc2", 8'(acc), 8'd9);

        // Reset in HOLD discards the result.
        issue(LOAD, 4'd6);
        rst = 1'b1;
        #1;
        check("rh_valid", 8'(res_valid), 8'd0);
        check("rh_acc", 8'(acc), 8'd0);
        check("rh_res", 8'({res_data, res_carry, res_zero, res_over}), 8'd0);
        check("rh_cnt", op_count, 8'd0);
        check("rh_ready", 8'(cmd_ready), 8'd1);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        issue(ADD, 4'd3);
        check_res("post_rst_add", 4'd3, 3'b000);
        handshake();
        check("post_rst_cnt", op_count, 8'd1);

        // Count wraps after 256 handshakes.
        for (int i = 0; i < 254; i++) begin
            issue(LOAD, 4'(i));
            handshake();
        end
        check("cnt255", op_count, 8'd255);
        issue(LOAD, 4'd1);
        handshake();
        check("cnt_wrap", op_count, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
